// File: rtl/servo_pkg.sv
// Shared constants, FSM encoding and helpers for the servo feedback scheduler.
package servo_pkg;

  localparam int NUM_CH_DEF  = 4;
  localparam int CNT_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 500000;
  localparam int SYNC_DEF    = 2;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SELECT    = 3'd1;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
  localparam logic [2:0] ST_WAIT_RISE = 3'd3;
  localparam logic [2:0] ST_MEASURE   = 3'd4;
  localparam logic [2:0] ST_REPORT    = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    SELECT    = ST_SELECT,
    WAIT_LOW  = ST_WAIT_LOW,
    WAIT_RISE = ST_WAIT_RISE,
    MEASURE   = ST_MEASURE,
    REPORT    = ST_REPORT
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/servo_pulse_capture.sv
// Synchronizer chain and edge detector for one servo feedback line.
module servo_pulse_capture #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/servo_feedback_scheduler.sv
// Round-robin pulse-width capture shared across NUM_CH servo feedback lines.
module servo_feedback_scheduler
  import servo_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int SYNC_STAGES = SYNC_DEF,
  localparam int CH_W       = clog2(NUM_CH)
) (
  input  logic                    clock_clk,
  input  logic                    reset_high,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH-1:0]       pwm_response,
  output logic                    angle_valid,
  output logic [CH_W-1:0]         angle_ch,
  output logic [CNT_W-1:0]        angle_data,
  output logic                    timeout_flag,
  output logic [NUM_CH*CNT_W-1:0] angle_flat,
  output logic                    busy
);

  localparam int DW   = clog2(TIMEOUT_CYC);
  localparam int TLIM = TIMEOUT_CYC - 1;
  localparam int LAST = NUM_CH - 1;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   cur_q, cur_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  data_q, data_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic              valid_q, valid_d;
  logic              to_q, to_d;
  logic [CNT_W-1:0]  flat_q [NUM_CH];
  logic              flat_we;

  logic [NUM_CH-1:0] rise_v, fall_v, level_v;
  logic              rise, fall, level;
  logic              hit, go_on;
  logic [CH_W-1:0]   nxt_rr, pick;

  logic [2*NUM_CH-1:0] rot;
  logic [CH_W-1:0]     off;
  logic [CH_W:0]       sum;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cap
    servo_pulse_capture #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cap (
      .clk_i  (clock_clk),
      .rst_i  (reset_high),
      .pin_i  (pwm_response[g]),
      .rise_o (rise_v[g]),
      .fall_o (fall_v[g]),
      .level_o(level_v[g])
    );
    assign angle_flat[g*CNT_W +: CNT_W] = flat_q[g];
  end

  assign rise   = rise_v[cur_q];
  assign fall   = fall_v[cur_q];
  assign level  = level_v[cur_q];
  assign hit    = (dwell_q == TLIM[DW-1:0]);
  assign go_on  = enable && (|ch_mask);
  assign nxt_rr = (cur_q == LAST[CH_W-1:0]) ? '0 : cur_q + 1'b1;

  // Rotate the mask so the search starts at rr_q, then map the offset back.
  always_comb begin
    rot = {ch_mask, ch_mask} >> rr_q;
    off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = i[CH_W-1:0];
    end
    sum = {1'b0, rr_q} + {1'b0, off};
    if (sum >= NUM_CH[CH_W:0]) sum = sum - NUM_CH[CH_W:0];
    pick = sum[CH_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    valid_d = 1'b0;
    to_d    = 1'b0;
    data_d  = data_q;
    ch_d    = ch_q;
    flat_we = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|ch_mask) state_d = SELECT;
        end
        SELECT: begin
          if (|ch_mask) begin
            cur_d   = pick;
            cnt_d   = '0;
            dwell_d = '0;
            state_d = WAIT_LOW;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_LOW, WAIT_RISE, MEASURE: begin
          dwell_d = dwell_q + 1'b1;
          // A falling edge on the last dwell cycle still counts as a result.
          if (state_q == MEASURE && fall) begin
            state_d = REPORT;
          end else if (hit) begin
            valid_d = 1'b1;
            to_d    = 1'b1;
            data_d  = '0;
            ch_d    = cur_q;
            rr_d    = nxt_rr;
            state_d = go_on ? SELECT : IDLE;
          end else if (state_q == WAIT_LOW) begin
            if (!level) state_d = WAIT_RISE;
          end else if (state_q == WAIT_RISE) begin
            if (rise) begin
              cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
              state_d = MEASURE;
            end
          end else if (level && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REPORT: begin
          valid_d = 1'b1;
          data_d  = cnt_q;
          ch_d    = cur_q;
          rr_d    = nxt_rr;
          flat_we = 1'b1;
          state_d = go_on ? SELECT : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_clk or posedge reset_high) begin
    if (reset_high) begin
      state_q <= IDLE;
      rr_q    <= '0;
      cur_q   <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      dwell_q <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) flat_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cur_q   <= cur_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dwell_q <= dwell_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      if (flat_we) flat_q[cur_q] <= cnt_q;
    end
  end

  assign angle_valid  = valid_q;
  assign timeout_flag = to_q;
  assign angle_data   = data_q;
  assign angle_ch     = ch_q;
  assign busy         = (state_q != IDLE);

endmodule
